// File: rtl/regfile_wb_pkg.sv
// Shared constants, source identifiers and helpers for the register-file write-back arbiter.
package regfile_wb_pkg;

    localparam int NUM_SRC    = 4;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        SRC_LOAD = 2'd0,
        SRC_JUMP = 2'd1,
        SRC_LUI  = 2'd2,
        SRC_ALU  = 2'd3
    } src_e;

    // One-hot register mask; x0 never produces a bit so it can never become busy.
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] r);
        logic [NUM_REGS-1:0] m;
        m    = '0;
        m[r] = (r != '0);
        return m;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bundle: one valid/rd/data lane per source plus the one-hot ready vector.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 4
);

    // Handshake: a source raises src_valid[i] with src_rd[i]/src_data[i] and holds all three
    // stable until the cycle src_ready[i] is also high; that rising edge is the transfer.
    // src_ready is combinational, at most one bit high, and only ever for a valid source.
    logic [NUM_SRC-1:0]                                src_valid;
    logic [NUM_SRC-1:0][regfile_wb_pkg::REG_ADDR_W-1:0] src_rd;
    logic [NUM_SRC-1:0][DATA_W-1:0]                    src_data;
    logic [NUM_SRC-1:0]                                src_ready;

    modport master (
        output src_valid,
        output src_rd,
        output src_data,
        input  src_ready
    );

    modport slave (
        input  src_valid,
        input  src_rd,
        input  src_data,
        output src_ready
    );

endinterface

// File: rtl/wb_rr_arbiter.sv
// Grant selection for write-back sources: round-robin when WB_ROUND_ROBIN_EN is defined,
// fixed lowest-index-first priority otherwise.
module wb_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

`ifdef WB_ROUND_ROBIN_EN
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    // ptr_q is the first source searched; it moves one past the winner on every transfer.
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        // Walk offsets from far to near so the nearest requester overwrites any farther one.
        for (int k = N - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                ptr_d      = PW'((idx + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Lowest set bit wins: LOAD > JUMP > LUI > ALU.
    assign grant = req & (~req + 1'b1);

    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter with busy scoreboard and hazard stall.
// Define WB_ROUND_ROBIN_EN for round-robin grant; the default build is fixed priority.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_wb_arbiter_if.slave    src,
    input  logic                   alloc_valid,
    input  logic [REG_ADDR_W-1:0]  alloc_rd,
    input  logic [REG_ADDR_W-1:0]  rs1,
    input  logic [REG_ADDR_W-1:0]  rs2,
    output logic                   stall,
    output logic                   wr_en,
    output logic [REG_ADDR_W-1:0]  wr_addr,
    output logic [DATA_W-1:0]      wr_data,
    output logic [NUM_REGS-1:0]    busy_vec
);

    logic [NUM_SRC-1:0]    req;
    logic [NUM_SRC-1:0]    grant;
    logic                  xfer;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0]     sel_data;
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   set_mask;
    logic [NUM_REGS-1:0]   clr_mask;

    // No grant while reset is held, so nothing can hand off into a register being cleared.
    assign req = src.src_valid & {NUM_SRC{~reset}};

    wb_rr_arbiter #(
        .N (NUM_SRC)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .grant (grant)
    );

    assign src.src_ready = grant;
    assign xfer          = |grant;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                sel_rd   = src.src_rd[i];
                sel_data = src.src_data[i];
            end
        end
    end

    // Writes to x0 still complete the handshake but never reach the register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= xfer && (sel_rd != '0);
            if (xfer) begin
                wr_addr <= sel_rd;
                wr_data <= sel_data;
            end
        end
    end

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (alloc_valid) begin
            set_mask = reg_mask(alloc_rd);
        end
        if (wr_en) begin
            clr_mask = reg_mask(wr_addr);
        end
    end

    // Set is applied after clear so a same-edge allocate and retire leaves the register busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~clr_mask) | set_mask;
        end
    end

    assign busy_vec = busy_q;

    // Looks at the registered scoreboard, so a register retiring this cycle still stalls.
    assign stall = ((rs1 != '0) && busy_q[rs1]) || ((rs2 != '0) && busy_q[rs2]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a cycle-by-cycle behavioural model;
// builds with or without WB_ROUND_ROBIN_EN.
module tb_regfile_wb_arbiter;
    import regfile_wb_pkg::*;

    localparam int DATA_W = 32;
    localparam int NSRC   = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        stall;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] busy_vec;

    regfile_wb_arbiter_if #(.DATA_W(DATA_W), .NUM_SRC(NSRC)) src_if ();

    regfile_wb_arbiter #(
        .DATA_W  (DATA_W),
        .NUM_SRC (NSRC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .src         (src_if),
        .alloc_valid (alloc_valid),
        .alloc_rd    (alloc_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .stall       (stall),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy_vec    (busy_vec)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int tests_run    = 0;
    int tests_failed = 0;
    logic [1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_ptr = 0;
    bit          m_pend_en = 1'b0;
    int          m_pend_addr = 0;
    logic [31:0] m_pend_data = '0;
    bit          m_busy[32];

    function automatic logic [3:0] model_grant(input logic [3:0] v, input int start);
`ifdef WB_ROUND_ROBIN_EN
        for (int k = 0; k < 4; k++) begin
            int s;
            s = (start + k) % 4;
            if (v[s]) return 4'b0001 << s;
        end
`else
        for (int s = 0; s < 4; s++) begin
            if (v[s]) return 4'b0001 << s;
        end
`endif
        return 4'b0000;
    endfunction

    initial begin : compare
        logic [3:0]  exp_ready;
        logic [31:0] exp_busy;
        logic        exp_stall;
        int          g;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_ptr     = 0;
                m_pend_en = 1'b0;
                foreach (m_busy[r]) m_busy[r] = 1'b0;
                check("rst_src_ready", src_if.src_ready, 0);
                check("rst_wr_en", wr_en, 0);
                check("rst_wr_addr", wr_addr, 0);
                check("rst_wr_data", wr_data, 0);
                check("rst_busy_vec", busy_vec, 0);
            end else begin
                exp_ready = model_grant(src_if.src_valid, m_ptr);
                exp_busy  = '0;
                foreach (m_busy[r]) exp_busy[r] = m_busy[r];
                exp_stall = ((rs1 != 0) && m_busy[rs1]) || ((rs2 != 0) && m_busy[rs2]);
                check("src_ready", src_if.src_ready, exp_ready);
                check("wr_en", wr_en, m_pend_en);
                if (m_pend_en) begin
                    check("wr_addr", wr_addr, m_pend_addr);
                    check("wr_data", wr_data, m_pend_data);
                end
                check("busy_vec", busy_vec, exp_busy);
                check("stall", stall, exp_stall);
                // next state at the coming rising edge
                if (m_pend_en) m_busy[m_pend_addr] = 1'b0;
                if (alloc_valid && alloc_rd != 0) m_busy[alloc_rd] = 1'b1;
                g = -1;
                for (int i = 0; i < 4; i++) if (exp_ready[i]) g = i;
                if (g >= 0) begin
                    m_ptr       = (g + 1) % 4;
                    m_pend_en   = (src_if.src_rd[g] != 0);
                    m_pend_addr = int'(src_if.src_rd[g]);
                    m_pend_data = src_if.src_data[g];
                end else begin
                    m_pend_en = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [4:0] rd, input logic [31:0] data);
        src_if.src_valid[i] = 1'b1;
        src_if.src_rd[i]    = rd;
        src_if.src_data[i]  = data;
    endtask

    task automatic alloc(input logic [4:0] rd);
        alloc_valid = 1'b1;
        alloc_rd    = rd;
        step();
        alloc_valid = 1'b0;
    endtask

    // Sources drop valid after their own transfer; grants are matched against exp_q in order.
    task automatic run_grants(input int budget);
        logic [3:0] got;
        logic [1:0] e;
        int cycles;
        cycles = 0;
        while (src_if.src_valid != 0 && cycles < budget) begin
            @(negedge clk);
            got = src_if.src_ready;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("grant_order", got, 4'b0001 << e);
            end else begin
                check("grant_extra", got, 0);
            end
            step();
            src_if.src_valid = src_if.src_valid & ~got;
            cycles++;
        end
        check("grants_done", src_if.src_valid, 0);
        check("grants_all_seen", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Sources keep valid high throughout; one expected grant per cycle.
    task automatic run_hold(input int n);
        logic [1:0] e;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("hold_grant", src_if.src_ready, 4'b0001 << e);
            end else begin
                check("hold_queue", c, n);
            end
            step();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : stimulus
        src_if.src_valid = '0;
        src_if.src_rd    = '0;
        src_if.src_data  = '0;
        alloc_valid = 1'b0;
        alloc_rd    = '0;
        rs1         = '0;
        rs2         = '0;
        reset       = 1'b1;
        step();
        step();
        reset = 1'b0;

        // single ALU request
        set_src(SRC_ALU, 5'd5, 32'h0800_8005);
        exp_q.push_back(SRC_ALU);
        run_grants(4);
        @(negedge clk);
        check("alu_wr_en", wr_en, 1);
        check("alu_wr_addr", wr_addr, 5);
        check("alu_wr_data", wr_data, 32'h0800_8005);
        step();

        // all four valid, held until served; then re-request
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) set_src(i, 5'(i + 1), 32'h1111_0000 + 32'(16 * r + i));
            for (int i = 0; i < 4; i++) exp_q.push_back(2'(i));
            run_grants(8);
        end
        step();

        // x0 write-back: handshake only
        alloc(5'd9);
        set_src(SRC_LOAD, 5'd0, 32'hFFFF_FFFF);
        exp_q.push_back(SRC_LOAD);
        run_grants(4);
        @(negedge clk);
        check("x0_wr_en", wr_en, 0);
        check("x0_busy_vec", busy_vec, 32'h0000_0200);
        step();
        alloc(5'd0);
        @(negedge clk);
        check("x0_alloc_ignored", busy_vec, 32'h0000_0200);
        step();
        set_src(SRC_ALU, 5'd9, 32'h0000_0099);
        exp_q.push_back(SRC_ALU);
        run_grants(4);
        step();

        // hazard: alloc rd=7, retire, then same-edge alloc/retire
        rs1 = 5'd7;
        alloc(5'd7);
        @(negedge clk);
        check("haz_stall_set", stall, 1);
        check("haz_busy", busy_vec, 32'h0000_0080);
        step();
        set_src(SRC_ALU, 5'd7, 32'h0000_00A7);
        exp_q.push_back(SRC_ALU);
        run_grants(4);
        @(negedge clk);
        check("haz_wr_addr", wr_addr, 7);
        check("haz_stall_on_write", stall, 1);
        step();
        @(negedge clk);
        check("haz_stall_cleared", stall, 0);
        step();
        alloc(5'd7);
        set_src(SRC_ALU, 5'd7, 32'h0000_00B7);
        exp_q.push_back(SRC_ALU);
        run_grants(4);
        alloc(5'd7);
        @(negedge clk);
        check("same_edge_busy", busy_vec, 32'h0000_0080);
        step();
        rs1 = 5'd0;
        rs2 = 5'd7;
        @(negedge clk);
        check("rs2_stall", stall, 1);
        step();
        set_src(SRC_ALU, 5'd7, 32'h0000_00C7);
        exp_q.push_back(SRC_ALU);
        run_grants(4);
        step();
        @(negedge clk);
        check("rs2_stall_cleared", stall, 0);
        step();
        rs2 = 5'd0;

        // reset the cycle after a transfer
        alloc(5'd20);
        set_src(SRC_JUMP, 5'd13, 32'h1300_0013);
        exp_q.push_back(SRC_JUMP);
        run_grants(4);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) set_src(i, 5'(i + 1), 32'h2222_0000 + 32'(i));
        @(negedge clk);
        check("rst_mid_wr_en", wr_en, 0);
        check("rst_mid_busy", busy_vec, 0);
        check("rst_mid_ready", src_if.src_ready, 0);
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(2'(i));
        run_grants(8);
        step();

        // LOAD and ALU continuously valid
        set_src(SRC_LOAD, 5'd10, 32'h0000_0A0A);
        set_src(SRC_ALU, 5'd11, 32'h0000_0B0B);
        for (int c = 0; c < 6; c++) begin
`ifdef WB_ROUND_ROBIN_EN
            exp_q.push_back((c % 2 == 0) ? SRC_LOAD : SRC_ALU);
`else
            exp_q.push_back(SRC_LOAD);
`endif
        end
        run_hold(6);
        src_if.src_valid = '0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
